dcache_lane_arbiter: RTL

- Shares the single dcache port between the two execute lanes (lane 0 = older slot, lane 1 = younger slot).
- Replaces the combinational valid-bit mux in the core top.
- Grants one request per cycle in program order and tracks in-flight reads in an owner queue.
- Steers each dcache read response back to the lane that issued it; responses for flushed requests are discarded.

---
 rtl/dcache_lane_arbiter_pkg.sv | 22 ++
 rtl/dcache_owner_fifo.sv | 65 ++++++
 rtl/dcache_lane_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dcache_lane_arbiter_pkg.sv
// Shared types and bus-width helpers for the two-lane dcache port arbiter.
package dcache_lane_arbiter_pkg;

    localparam int LANE_ID_W = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_PEND = 2'd1,
        ST_DRAIN   = 2'd2
    } arb_state_e;

    // Packed request bus {op, addr, uncached, awstrb, wdata} as a lane drives it.
    function automatic int exm_dcache_wd_w(input int addr_w, input int data_w);
        return 1 + addr_w + 1 + 4 + data_w;
    endfunction

    // Packed response bus {rvalid, rdata}.
    function automatic int exm_dcache_rd_w(input int data_w);
        return 1 + data_w;
    endfunction

endpackage

// File: rtl/dcache_owner_fifo.sv
// Ring of {owner, kill} tags for in-flight dcache reads, oldest at the head.
module dcache_owner_fifo
    import dcache_lane_arbiter_pkg::*;
#(
    parameter int MAX_OUT = 2,
    localparam int CNT_W = $clog2(MAX_OUT + 1)
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 push,
    input  logic [LANE_ID_W-1:0] push_owner,
    input  logic                 pop,
    input  logic                 kill_all,
    output logic [LANE_ID_W-1:0] head_owner,
    output logic                 head_kill,
    output logic [CNT_W-1:0]     count
);

    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [LANE_ID_W-1:0] r_owner [MAX_OUT];
    logic [MAX_OUT-1:0]   r_kill;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUT - 1)) ? PTR_W'(0) : p + PTR_W'(1);
    endfunction

    // Entry storage, pointers and occupancy; a push during kill_all is born dead.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < MAX_OUT; i++) begin
                r_owner[i] <= '0;
            end
            r_kill   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (kill_all) begin
                r_kill <= '1;
            end
            if (push) begin
                r_owner[r_wr_ptr] <= push_owner;
                r_kill[r_wr_ptr]  <= kill_all;
                r_wr_ptr          <= next_ptr(r_wr_ptr);
            end
            if (pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_owner = r_owner[r_rd_ptr];
    assign head_kill  = r_kill[r_rd_ptr];
    assign count      = r_count;

endmodule

// File: rtl/dcache_lane_arbiter.sv
// Shares the dcache request port between two execute lanes in program order
// and steers read responses back to the lane that issued them.
module dcache_lane_arbiter
    import dcache_lane_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 2
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              flush,
    input  logic              l0_valid,
    output logic              l0_ready,
    input  logic              l0_op,
    input  logic [ADDR_W-1:0] l0_addr,
    input  logic              l0_uncached,
    input  logic [3:0]        l0_awstrb,
    input  logic [DATA_W-1:0] l0_wdata,
    output logic              l0_rvalid,
    output logic [DATA_W-1:0] l0_rdata,
    input  logic              l1_valid,
    output logic              l1_ready,
    input  logic              l1_op,
    input  logic [ADDR_W-1:0] l1_addr,
    input  logic              l1_uncached,
    input  logic [3:0]        l1_awstrb,
    input  logic [DATA_W-1:0] l1_wdata,
    output logic              l1_rvalid,
    output logic [DATA_W-1:0] l1_rdata,
    output logic              dc_valid,
    input  logic              dc_ready,
    output logic              dc_op,
    output logic [ADDR_W-1:0] dc_addr,
    output logic              dc_uncached,
    output logic [3:0]        dc_awstrb,
    output logic [DATA_W-1:0] dc_wdata,
    input  logic              dc_rvalid,
    input  logic [DATA_W-1:0] dc_rdata,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W         = $clog2(MAX_OUT + 1);
    localparam int EXM_DCACHE_WD = exm_dcache_wd_w(ADDR_W, DATA_W);

    arb_state_e r_state;
    logic       r_err;

    logic [EXM_DCACHE_WD-1:0] w_l0_req;
    logic [EXM_DCACHE_WD-1:0] w_l1_req;
    logic [EXM_DCACHE_WD-1:0] w_sel_req;
    logic [EXM_DCACHE_WD-1:0] w_dc_req;
    logic [CNT_W-1:0]         w_cnt;
    logic [CNT_W-1:0]         w_cnt_nxt;
    logic [LANE_ID_W-1:0]     w_head_owner;
    logic                     w_head_kill;
    logic                     w_sel;
    logic                     w_sel_op;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_can_issue;
    logic                     w_dc_valid;
    logic                     w_accept;
    logic                     w_deliver;

    assign w_l0_req = {l0_op, l0_addr, l0_uncached, l0_awstrb, l0_wdata};
    assign w_l1_req = {l1_op, l1_addr, l1_uncached, l1_awstrb, l1_wdata};

    // Program-order select and issue check; a write needs the queue empty by the end of the cycle.
    always_comb begin
        w_sel       = ~l0_valid;
        w_sel_req   = w_sel ? w_l1_req : w_l0_req;
        w_sel_op    = w_sel_req[EXM_DCACHE_WD-1];
        w_can_issue = 1'b0;
        if ((r_state == ST_DRAIN) || flush) begin
            w_can_issue = 1'b0;
        end else if (w_sel_op) begin
            w_can_issue = (w_cnt == CNT_W'(0)) || ((w_cnt == CNT_W'(1)) && w_pop);
        end else begin
            w_can_issue = (w_cnt < CNT_W'(MAX_OUT)) || w_pop;
        end
    end

    assign w_pop      = dc_rvalid & (w_cnt != CNT_W'(0));
    assign w_dc_valid = aresetn & (l0_valid | l1_valid) & w_can_issue;
    assign w_accept   = w_dc_valid & dc_ready;
    assign w_push     = w_accept & ~w_sel_op;
    assign w_cnt_nxt  = w_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_deliver  = w_pop & ~w_head_kill & ~flush;
    assign w_dc_req   = w_dc_valid ? w_sel_req : '0;

    dcache_owner_fifo #(
        .MAX_OUT (MAX_OUT)
    ) u_owner_fifo (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .push       (w_push),
        .push_owner (LANE_ID_W'(w_sel)),
        .pop        (w_pop),
        .kill_all   (flush),
        .head_owner (w_head_owner),
        .head_kill  (w_head_kill),
        .count      (w_cnt)
    );

    // Arbiter state plus the sticky orphan-response error flag.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b0;
        end else begin
            if (dc_rvalid && (w_cnt == CNT_W'(0))) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE, ST_RD_PEND: begin
                    if (flush && (w_cnt_nxt != CNT_W'(0))) begin
                        r_state <= ST_DRAIN;
                    end else if (w_cnt_nxt != CNT_W'(0)) begin
                        r_state <= ST_RD_PEND;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (w_cnt_nxt == CNT_W'(0)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dc_valid = w_dc_valid;
    assign {dc_op, dc_addr, dc_uncached, dc_awstrb, dc_wdata} = w_dc_req;
    assign l0_ready  = w_accept & ~w_sel;
    assign l1_ready  = w_accept & w_sel;
    assign l0_rvalid = w_deliver & (w_head_owner == LANE_ID_W'(0));
    assign l1_rvalid = w_deliver & (w_head_owner == LANE_ID_W'(1));
    assign l0_rdata  = aresetn ? dc_rdata : '0;
    assign l1_rdata  = aresetn ? dc_rdata : '0;
    assign busy      = aresetn & (w_cnt != CNT_W'(0));
    assign err       = r_err;

endmodule
